mlblock_2dflex_seq: RTL and testbench

Sequencer for one MLBlock_2Dflex tile operation. It accepts a job through a start/busy/done handshake and shifts the job's configuration word into the block's serial config chain. It then asserts the weight-load, input-stream and accumulate enables for the programmed cycle counts, waits out the datapath pipeline, and flags when the result is valid. It sits between the tile scheduler and one MLBlock_2Dflex instance and drives all of that instance's control inputs.

---
 rtl/mlblock_2dflex_seq.sv | 204 ++++++++++++++++++++
 tb/tb_mlblock_2dflex_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mlblock_2dflex_seq.sv
// mlblock_2dflex_seq
// Control sequencer for one MLBlock_2Dflex tile operation.
// A job is accepted via start/busy/done. The sequencer then:
//   1. shifts the configuration word into the serial config chain (MSB first);
//   2. holds W_en to load the weight registers;
//   3. streams inputs and accumulates for acc_len non-stalled cycles;
//   4. waits out the datapath pipeline;
//   5. pulses done (and res_valid when acc_len is nonzero).
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   start               job request, sampled only in IDLE
//   cfg_word            chain image, bit CFG_LEN-1 shifted first
//   cfg_skip            keep the current chain contents and skip CFG
//   mode, hp_en_req     captured at start, driven on configg / hp_en
//   acc_len             number of accumulate cycles
//   first_tile          captured at start, forces Res_cas_in_zero in COMPUTE
//   stall               pauses COMPUTE
//   busy, done, res_valid        job handshake
//   configg, hp_en               registered job mode
//   config_en, config_in         serial config chain drive
//   W_en, I_en, Res_en, Res_cas_in_zero   datapath enables
module mlblock_2dflex_seq #(
  parameter int CFG_LEN          = 16,
  parameter int N_OF_COFIGS_LOG2 = 2,
  parameter int W_LOAD_CYCLES    = 4,
  parameter int PIPE_LAT         = 3,
  parameter int CNT_W            = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CFG_LEN-1:0]          cfg_word,
  input  logic                        cfg_skip,
  input  logic [N_OF_COFIGS_LOG2-1:0] mode,
  input  logic                        hp_en_req,
  input  logic [CNT_W-1:0]            acc_len,
  input  logic                        first_tile,
  input  logic                        stall,
  output logic                        busy,
  output logic                        done,
  output logic                        res_valid,
  output logic [N_OF_COFIGS_LOG2-1:0] configg,
  output logic                        hp_en,
  output logic                        config_en,
  output logic                        config_in,
  output logic                        W_en,
  output logic                        I_en,
  output logic                        Res_en,
  output logic                        Res_cas_in_zero
);

  localparam int SH_W = (CFG_LEN > 1)       ? $clog2(CFG_LEN)       : 1;
  localparam int WL_W = (W_LOAD_CYCLES > 1) ? $clog2(W_LOAD_CYCLES) : 1;
  localparam int DR_W = (PIPE_LAT > 1)      ? $clog2(PIPE_LAT)      : 1;

  localparam logic [SH_W-1:0] SH_INIT = SH_W'(CFG_LEN - 1);
  localparam logic [WL_W-1:0] WL_INIT = WL_W'(W_LOAD_CYCLES - 1);
  localparam logic [DR_W-1:0] DR_INIT = DR_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CFG     = 3'd1,
    WLOAD   = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             state, state_n;
  logic [SH_W-1:0]    sh_cnt, sh_cnt_n;
  logic [WL_W-1:0]    wl_cnt, wl_cnt_n;
  logic [DR_W-1:0]    dr_cnt, dr_cnt_n;
  logic [CNT_W-1:0]   rem, rem_n;
  logic [CFG_LEN-1:0] cfg_sr, cfg_sr_n;
  logic [CNT_W-1:0]   acc_q;
  logic               first_q;
  logic               accept;
  logic               in_compute;

  // Next-state and counter logic. Every counter is loaded on entry to its
  // state and counts down to zero, so no counter can wrap.
  always_comb begin
    state_n  = state;
    sh_cnt_n = sh_cnt;
    wl_cnt_n = wl_cnt;
    dr_cnt_n = dr_cnt;
    rem_n    = rem;
    accept   = (state == IDLE) && start;
    cfg_sr_n = cfg_sr;

    case (state)
      IDLE: begin
        if (start) begin
          state_n  = cfg_skip ? WLOAD : CFG;
          sh_cnt_n = SH_INIT;
          wl_cnt_n = WL_INIT;
          cfg_sr_n = cfg_word;
        end
      end
      CFG: begin
        cfg_sr_n = cfg_sr << 1;
        if (sh_cnt == '0) begin
          state_n  = WLOAD;
          wl_cnt_n = WL_INIT;
        end else begin
          sh_cnt_n = sh_cnt - SH_W'(1);
        end
      end
      WLOAD: begin
        if (wl_cnt == '0) begin
          if (acc_q == '0) begin
            state_n = DONE;
          end else begin
            state_n = COMPUTE;
            rem_n   = acc_q;
          end
        end else begin
          wl_cnt_n = wl_cnt - WL_W'(1);
        end
      end
      COMPUTE: begin
        if (!stall) begin
          if (rem == CNT_W'(1)) begin
            state_n  = (PIPE_LAT == 0) ? DONE : DRAIN;
            dr_cnt_n = DR_INIT;
          end else begin
            rem_n = rem - CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (dr_cnt == '0) begin
          state_n = DONE;
        end else begin
          dr_cnt_n = dr_cnt - DR_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Job data: the shift image and the latched job fields are not reset. A
  // chain interrupted by reset is left as-is and is overwritten by the next
  // job.
  always_ff @(posedge clk) begin
    cfg_sr <= cfg_sr_n;
    if (accept) begin
      acc_q   <= acc_len;
      first_q <= first_tile;
    end
  end

  // State, counters and registered outputs. The outputs are decoded from
  // the next state so that each output lines up with the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      sh_cnt          <= '0;
      wl_cnt          <= '0;
      dr_cnt          <= '0;
      rem             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      res_valid       <= 1'b0;
      configg         <= '0;
      hp_en           <= 1'b0;
      config_en       <= 1'b0;
      config_in       <= 1'b0;
      W_en            <= 1'b0;
      in_compute      <= 1'b0;
      Res_cas_in_zero <= 1'b0;
    end else begin
      state           <= state_n;
      sh_cnt          <= sh_cnt_n;
      wl_cnt          <= wl_cnt_n;
      dr_cnt          <= dr_cnt_n;
      rem             <= rem_n;
      busy            <= (state_n != IDLE);
      done            <= (state_n == DONE);
      res_valid       <= (state_n == DONE) && (acc_q != '0);
      config_en       <= (state_n == CFG);
      config_in       <= (state_n == CFG) && cfg_sr_n[CFG_LEN-1];
      W_en            <= (state_n == WLOAD);
      in_compute      <= (state_n == COMPUTE);
      Res_cas_in_zero <= (state_n == COMPUTE) && first_q;
      if (accept) begin
        configg <= mode;
        hp_en   <= hp_en_req;
      end
    end
  end

  // stall gates the streaming enables combinationally, so a stalled cycle
  // neither consumes an input nor accumulates.
  assign I_en   = in_compute & ~stall;
  assign Res_en = in_compute & ~stall;

endmodule

// File: tb/tb_mlblock_2dflex_seq.sv
// Testbench for mlblock_2dflex_seq: table-driven jobs, hand-written
// reset / back-to-back sequences, and random jobs checked cycle by cycle
// against a phase-window model of the sequencer.
module tb_mlblock_2dflex_seq;

  localparam int CFG_LEN = 16;
  localparam int NCL     = 2;
  localparam int WL      = 4;
  localparam int PL      = 3;
  localparam int CW      = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CFG_LEN-1:0] cfg_word;
  logic              cfg_skip;
  logic [NCL-1:0]    mode;
  logic              hp_en_req;
  logic [CW-1:0]     acc_len;
  logic              first_tile;
  logic              stall;
  logic              busy, done, res_valid, hp_en;
  logic [NCL-1:0]    configg;
  logic              config_en, config_in, W_en, I_en, Res_en, Res_cas_in_zero;

  mlblock_2dflex_seq #(
    .CFG_LEN(CFG_LEN), .N_OF_COFIGS_LOG2(NCL), .W_LOAD_CYCLES(WL),
    .PIPE_LAT(PL), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_word(cfg_word),
    .cfg_skip(cfg_skip), .mode(mode), .hp_en_req(hp_en_req),
    .acc_len(acc_len), .first_tile(first_tile), .stall(stall),
    .busy(busy), .done(done), .res_valid(res_valid), .configg(configg),
    .hp_en(hp_en), .config_en(config_en), .config_in(config_in),
    .W_en(W_en), .I_en(I_en), .Res_en(Res_en),
    .Res_cas_in_zero(Res_cas_in_zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit stl [0:511];

  typedef struct {
    logic [15:0] w;
    bit          skip;
    logic [1:0]  md;
    bit          hp;
    logic [15:0] acc;
    bit          ft;
    logic [15:0] smask;     // bit i set: stall on COMPUTE cycle i+1
    int          exp_done;
    int          exp_ien;
  } vec_t;

  vec_t tbl [4];

  function automatic logic [11:0] dut_vec();
    return {busy, done, res_valid, config_en, config_in, W_en, I_en, Res_en,
            Res_cas_in_zero, configg, hp_en};
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s [%0d] got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic clear_stall();
    for (int k = 0; k < 512; k++) stl[k] = 1'b0;
  endtask

  // Runs one job from IDLE and checks every cycle from 1 to done+1 against
  // phase windows derived from the job parameters: CFG, WLOAD, COMPUTE (which
  // ends on the acc-th non-stalled cycle), DRAIN, DONE.
  task automatic run_job(input logic [15:0] w, input bit skip,
                         input logic [1:0] md, input bit hp,
                         input logic [15:0] acc, input bit ft, input int id,
                         output int done_cyc, output int ien_cnt);
    int ws, we, cs, ce, dc, n, c;
    logic [11:0] exp;
    bit cen, cin, wen, inc, ien;
    ws = skip ? 1 : CFG_LEN + 1;
    we = ws + WL - 1;
    cs = we + 1;
    if (acc == 0) begin
      ce = we;
      dc = we + 1;
    end else begin
      n = 0;
      c = cs;
      while (c < 400) begin
        if (!stl[c]) n++;
        if (n == int'(acc)) break;
        c++;
      end
      ce = c;
      dc = ce + PL + 1;
    end
    cfg_word = w; cfg_skip = skip; mode = md; hp_en_req = hp;
    acc_len = acc; first_tile = ft; stall = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1;
    ien_cnt  = 0;
    for (int k = 1; k <= dc + 1; k++) begin
      stall = stl[k];
      @(negedge clk);
      cen = !skip && (k <= CFG_LEN);
      cin = 1'b0;
      if (cen) cin = w[CFG_LEN-k];
      wen = (k >= ws) && (k <= we);
      inc = (acc != 0) && (k >= cs) && (k <= ce);
      ien = inc && !stl[k];
      exp = {k <= dc, k == dc, (k == dc) && (acc != 0), cen, cin, wen,
             ien, ien, inc && ft, md, hp};
      check("trace", id * 1000 + k, 32'(dut_vec()), 32'(exp));
      if (done === 1'b1 && done_cyc < 0) done_cyc = k;
      if (I_en === 1'b1) ien_cnt++;
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
  endtask

  initial begin
    int dcyc, ien, cs, bcnt;
    tbl[0] = '{16'hA5C3, 1'b0, 2'd2, 1'b1, 16'd8, 1'b0, 16'h0000, 32, 8};
    tbl[1] = '{16'h1234, 1'b1, 2'd1, 1'b0, 16'd2, 1'b1, 16'h0000, 10, 2};
    tbl[2] = '{16'hFFFF, 1'b0, 2'd3, 1'b1, 16'd5, 1'b0, 16'h0006, 31, 5};
    tbl[3] = '{16'h0000, 1'b1, 2'd0, 1'b0, 16'd0, 1'b0, 16'h0000, 5,  0};

    reset = 1'b1; start = 1'b0; cfg_word = '0; cfg_skip = 1'b0; mode = '0;
    hp_en_req = 1'b0; acc_len = '0; first_tile = 1'b0; stall = 1'b0;
    #2;
    check("reset_state", 0, 32'(dut_vec()), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven jobs
    for (int i = 0; i < 4; i++) begin
      clear_stall();
      cs = (tbl[i].skip ? 0 : CFG_LEN) + WL + 1;
      for (int b = 0; b < 16; b++) stl[cs + b] = tbl[i].smask[b];
      run_job(tbl[i].w, tbl[i].skip, tbl[i].md, tbl[i].hp, tbl[i].acc,
              tbl[i].ft, i, dcyc, ien);
      check("done_cycle", i, 32'(dcyc), 32'(tbl[i].exp_done));
      check("ien_count", i, 32'(ien), 32'(tbl[i].exp_ien));
    end

    // Reset in the middle of COMPUTE, with start held high while busy
    clear_stall();
    cfg_word = 16'hA5C3; cfg_skip = 1'b0; mode = 2'd3; hp_en_req = 1'b1;
    acc_len = 16'd8; first_tile = 1'b1; stall = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (22) @(posedge clk);
    #1;
    check("pre_reset_compute", 0, 32'({I_en, Res_cas_in_zero, busy}), 32'h7);
    #1 reset = 1'b1;
    #1;
    check("async_reset_outputs", 0, 32'(dut_vec()), 32'h0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0) bcnt++;
    end
    check("no_second_job", 0, 32'(bcnt), 32'h0);
    @(posedge clk);
    #1;
    run_job(16'h3C5A, 1'b0, 2'd1, 1'b0, 16'd3, 1'b0, 10, dcyc, ien);
    check("fresh_job_done", 10, 32'(dcyc), 32'(CFG_LEN + WL + 3 + PL + 1));

    // Back-to-back with start held high: job A (mode 1), then job B (mode 2)
    clear_stall();
    cfg_word = 16'h00FF; cfg_skip = 1'b1; mode = 2'd1; hp_en_req = 1'b0;
    acc_len = 16'd1; first_tile = 1'b0; stall = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 mode = 2'd2;
    dcyc = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done === 1'b1 && dcyc < 0) dcyc = k;
      if (k == 10) begin
        check("b2b_idle_busy", k, 32'(busy), 32'h0);
        check("b2b_idle_configg", k, 32'(configg), 32'h1);
      end
      if (k == 11) begin
        check("b2b_accept_busy", k, 32'(busy), 32'h1);
        check("b2b_accept_configg", k, 32'(configg), 32'h2);
      end
      @(posedge clk);
      #1;
    end
    check("b2b_done_cycle", 0, 32'(dcyc), 32'd9);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Random jobs with random stalls over the whole job
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 512; k++) stl[k] = ($urandom_range(2) == 0);
      run_job(16'($urandom), bit'($urandom_range(1)), 2'($urandom_range(3)),
              bit'($urandom_range(1)), 16'($urandom_range(12)),
              bit'($urandom_range(1)), 100 + i, dcyc, ien);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
